bin_to_bcd_display_feeder: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double dabble) upstream of the
//  4-digit seven-segment display controller. Takes a binary count, produces packed
//  BCD nibbles on bcd_out for that controller's 32-bit displayed_number input, so the
//  hex-nibble display shows decimal. One conversion per start pulse; result held.

---
 rtl/bin_to_bcd_display_feeder.sv | 114 +++++++++++
 tb/tb_bin_to_bcd_display_feeder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_display_feeder.sv
// Sequential binary-to-BCD converter (double dabble) feeding the 7-segment display controller.
// Latency: done pulses BIN_WIDTH cycles after the accepting start edge; back-to-back period BIN_WIDTH+1.
// Backpressure: start is ignored while busy; no queuing; results hold until the next done.
module bin_to_bcd_display_feeder #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [31:0]          bcd_out
);

  localparam int SW     = 4 * DIGITS;
  localparam int ITER_W = $clog2(BIN_WIDTH) + 1;

  // Largest value that fits in DIGITS decimal digits.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0]   MAX_VAL = pow10(DIGITS) - 64'd1;
  localparam logic [SW-1:0] SAT_VAL = {DIGITS{4'h9}};

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;

  logic [0:0]           r_state;
  logic [BIN_WIDTH-1:0] r_shift;
  logic [SW-1:0]        r_scratch;
  logic [ITER_W-1:0]    r_iter;
  logic                 r_ovf_pend;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overflow;
  logic [SW-1:0]        r_bcd;

  logic [SW-1:0]        w_adj;
  logic [SW-1:0]        w_next_scratch;
  logic                 w_last;
  logic                 w_ovf;

  // Add-3 correction on every nibble >= 5, then one-bit shift pulling in the next binary MSB.
  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
      end
    end
    w_next_scratch = {w_adj[SW-2:0], r_shift[BIN_WIDTH-1]};
    w_last         = (r_iter == ITER_W'(BIN_WIDTH - 1));
    w_ovf          = (64'(bin_in) > MAX_VAL);
  end

  // Conversion FSM: accept in IDLE, shift BIN_WIDTH times, publish result with a done pulse.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_iter     <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_bcd      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift    <= bin_in;
            r_scratch  <= '0;
            r_iter     <= '0;
            r_ovf_pend <= w_ovf;
            r_busy     <= 1'b1;
            r_state    <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          r_scratch <= w_next_scratch;
          r_shift   <= r_shift << 1;
          r_iter    <= r_iter + 1'b1;
          if (w_last) begin
            // Out-of-range inputs still run full length but show all nines.
            r_bcd      <= r_ovf_pend ? SAT_VAL : w_next_scratch;
            r_overflow <= r_ovf_pend;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign bcd_out  = 32'(r_bcd);

endmodule

// File: tb/tb_bin_to_bcd_display_feeder.sv
// Self-checking bench for bin_to_bcd_display_feeder.
// Inputs driven and outputs sampled on the falling edge of clock_100Mhz.
// Decimal reference computed arithmetically from the input value.
module tb_bin_to_bcd_display_feeder;

  logic        clock_100Mhz = 1'b0;
  logic        reset        = 1'b1;
  logic        start        = 1'b0;
  logic [13:0] bin_in       = '0;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [31:0] bcd_out;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_display_feeder #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .start        (start),
    .bin_in       (bin_in),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .bcd_out      (bcd_out)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  typedef struct {
    logic [13:0] bin;
    logic [31:0] bcd;
    logic        ovf;
  } vec_t;

  function automatic logic [31:0] ref_bcd(input int v);
    logic [31:0] r;
    int t;
    if (v > 9999) return 32'h0000_9999;
    r = '0;
    t = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // One complete conversion with a single-cycle start pulse; checks busy, hold, latency, result, pulse width.
  task automatic do_conv(input logic [13:0] v, input logic [31:0] exp_bcd,
                         input logic exp_ovf, input string name);
    logic [31:0] prev;
    int lat;
    prev = bcd_out;
    @(negedge clock_100Mhz);
    bin_in = v;
    start  = 1'b1;
    @(negedge clock_100Mhz);
    start  = 1'b0;
    bin_in = ~v;
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_hold"}, bcd_out, prev);
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clock_100Mhz);
      lat++;
    end
    chk({name, "_lat"}, lat, 14);
    chk({name, "_bcd"}, bcd_out, exp_bcd);
    chk({name, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({name, "_idle"}, 32'(busy), 32'd0);
    @(negedge clock_100Mhz);
    chk({name, "_pulse"}, 32'(done), 32'd0);
    chk({name, "_held"}, bcd_out, exp_bcd);
  endtask

  initial begin
    vec_t tbl[12];
    int lat;
    int seen;
    logic [13:0] v;

    tbl[0]  = '{14'd1234,  32'h0000_1234, 1'b0};
    tbl[1]  = '{14'd0,     32'h0000_0000, 1'b0};
    tbl[2]  = '{14'd9999,  32'h0000_9999, 1'b0};
    tbl[3]  = '{14'd12345, 32'h0000_9999, 1'b1};
    tbl[4]  = '{14'd42,    32'h0000_0042, 1'b0};
    tbl[5]  = '{14'd10000, 32'h0000_9999, 1'b1};
    tbl[6]  = '{14'd1,     32'h0000_0001, 1'b0};
    tbl[7]  = '{14'd16383, 32'h0000_9999, 1'b1};
    tbl[8]  = '{14'd1000,  32'h0000_1000, 1'b0};
    tbl[9]  = '{14'd5,     32'h0000_0005, 1'b0};
    tbl[10] = '{14'd8765,  32'h0000_8765, 1'b0};
    tbl[11] = '{14'd90,    32'h0000_0090, 1'b0};

    // Reset state
    repeat (3) @(negedge clock_100Mhz);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    chk("rst_bcd",  bcd_out, 32'd0);
    reset = 1'b0;
    @(negedge clock_100Mhz);

    // Table vectors
    foreach (tbl[i]) do_conv(tbl[i].bin, tbl[i].bcd, tbl[i].ovf, $sformatf("tbl%0d", i));

    // Back-to-back: start held, bin_in switched after acceptance, second start lands on the done cycle
    @(negedge clock_100Mhz);
    bin_in = 14'd0;
    start  = 1'b1;
    @(negedge clock_100Mhz);
    bin_in = 14'd9999;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clock_100Mhz);
      lat++;
    end
    chk("b2b_lat0", lat, 14);
    chk("b2b_bcd0", bcd_out, 32'h0);
    @(negedge clock_100Mhz);
    start = 1'b0;
    chk("b2b_busy1", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clock_100Mhz);
      lat++;
    end
    chk("b2b_spacing", lat, 15);
    chk("b2b_bcd1", bcd_out, 32'h0000_9999);
    chk("b2b_ovf1", 32'(overflow), 32'd0);
    @(negedge clock_100Mhz);

    // Start held and re-pulsed while busy with another value: ignored
    bin_in = 14'd1234;
    start  = 1'b1;
    @(negedge clock_100Mhz);
    bin_in = 14'd7777;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 4 || lat == 8) start = 1'b0;
      if (lat == 6) start = 1'b1;
      @(negedge clock_100Mhz);
      lat++;
    end
    chk("ign_lat", lat, 14);
    chk("ign_bcd", bcd_out, 32'h0000_1234);
    @(negedge clock_100Mhz);
    chk("ign_idle", 32'(busy), 32'd0);

    // Reset in the middle of a conversion
    bin_in = 14'd5678;
    start  = 1'b1;
    @(negedge clock_100Mhz);
    start = 1'b0;
    repeat (6) @(negedge clock_100Mhz);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_bcd",  bcd_out, 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    @(negedge clock_100Mhz);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clock_100Mhz);
      if (done) seen++;
    end
    chk("mid_rst_nodone", seen, 0);
    chk("mid_rst_bcd_hold", bcd_out, 32'd0);
    do_conv(14'd5678, 32'h0000_5678, 1'b0, "restart");

    // Randomized values against the decimal reference
    for (int i = 0; i < 1500; i++) begin
      v = (i % 2 == 0) ? 14'($urandom_range(0, 9999)) : 14'($urandom_range(0, 16383));
      do_conv(v, ref_bcd(int'(v)), (v > 14'd9999), $sformatf("rnd%0d_%0d", i, v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
